// File: rtl/fpu_ss_pkg.sv
// Shared types for the coprocessor memory responder: id width, access size
// encoding and the per-request metadata carried until the response returns.
package fpu_ss_pkg;

    localparam int X_ID_WIDTH = 4;

    typedef enum logic [1:0] {
        MEM_SIZE_BYTE    = 2'd0,
        MEM_SIZE_HALF    = 2'd1,
        MEM_SIZE_WORD    = 2'd2,
        MEM_SIZE_ILLEGAL = 2'd3
    } mem_size_e;

    typedef struct packed {
        logic [X_ID_WIDTH-1:0] id;
        logic                  local_err;
    } mem_resp_meta_t;

    function automatic logic is_misaligned(input logic [1:0] addr_lo, input mem_size_e size);
        case (size)
            MEM_SIZE_BYTE: return 1'b0;
            MEM_SIZE_HALF: return addr_lo[0];
            MEM_SIZE_WORD: return addr_lo != 2'b00;
            default:       return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/xif_mem_responder_if.sv
// Coprocessor memory request/result bundle and the OBI data-bus bundle.
interface xif_mem_if import fpu_ss_pkg::*; ();
    logic                  x_mem_valid_i;
    logic                  x_mem_ready_o;
    logic [X_ID_WIDTH-1:0] x_mem_req_id_i;
    logic [31:0]           x_mem_req_addr_i;
    logic [31:0]           x_mem_req_wdata_i;
    logic                  x_mem_req_we_i;
    logic [1:0]            x_mem_req_size_i;
    logic                  x_mem_result_valid_o;
    logic [X_ID_WIDTH-1:0] x_mem_result_id_o;
    logic [31:0]           x_mem_result_rdata_o;
    logic                  x_mem_result_err_o;

    modport master (
        output x_mem_valid_i, x_mem_req_id_i, x_mem_req_addr_i, x_mem_req_wdata_i,
               x_mem_req_we_i, x_mem_req_size_i,
        input  x_mem_ready_o, x_mem_result_valid_o, x_mem_result_id_o,
               x_mem_result_rdata_o, x_mem_result_err_o
    );

    modport slave (
        input  x_mem_valid_i, x_mem_req_id_i, x_mem_req_addr_i, x_mem_req_wdata_i,
               x_mem_req_we_i, x_mem_req_size_i,
        output x_mem_ready_o, x_mem_result_valid_o, x_mem_result_id_o,
               x_mem_result_rdata_o, x_mem_result_err_o
    );
endinterface

interface obi_if ();
    logic        obi_req_o;
    logic        obi_gnt_i;
    logic [31:0] obi_addr_o;
    logic        obi_we_o;
    logic [3:0]  obi_be_o;
    logic [31:0] obi_wdata_o;
    logic        obi_rvalid_i;
    logic [31:0] obi_rdata_i;
    logic        obi_err_i;

    modport master (
        output obi_req_o, obi_addr_o, obi_we_o, obi_be_o, obi_wdata_o,
        input  obi_gnt_i, obi_rvalid_i, obi_rdata_i, obi_err_i
    );

    modport slave (
        input  obi_req_o, obi_addr_o, obi_we_o, obi_be_o, obi_wdata_o,
        output obi_gnt_i, obi_rvalid_i, obi_rdata_i, obi_err_i
    );
endinterface

// File: rtl/xif_mem_meta_fifo.sv
// In-order metadata FIFO holding {id, local_err} for every accepted request.
module xif_mem_meta_fifo import fpu_ss_pkg::*; #(
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         push_i,
    input  mem_resp_meta_t               push_data_i,
    input  logic                         pop_i,
    output logic                         full_o,
    output logic                         empty_o,
    output mem_resp_meta_t               head_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    mem_resp_meta_t   mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign full_o  = (count == CNT_W'(DEPTH));
    assign empty_o = (count == '0);
    assign head_o  = mem[rd_ptr];
    assign count_o = count;
    assign do_push = push_i & (~full_o | pop_i);
    assign do_pop  = pop_i & ~empty_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= push_data_i;
    end

endmodule

// File: rtl/xif_mem_responder.sv
// Bridges coprocessor memory requests onto an OBI data bus and returns
// in-order results; misaligned requests complete locally with an error.
module xif_mem_responder import fpu_ss_pkg::*; #(
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic     clk_i,
    input  logic     rst_i,
    xif_mem_if.slave xif,
    obi_if.master    obi
);

    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

    mem_size_e             size;
    logic                  misaligned;
    logic                  full;
    logic                  empty;
    logic [CNT_W-1:0]      count;
    mem_resp_meta_t        head;
    mem_resp_meta_t        push_meta;
    logic                  push;
    logic                  pop;
    logic                  resp_valid;
    logic [31:0]           resp_rdata;
    logic                  resp_err;
    logic                  skid_valid;
    logic [31:0]           skid_rdata;
    logic                  skid_err;
    logic                  skid_load;
    logic                  res_valid;
    logic [X_ID_WIDTH-1:0] res_id;
    logic [31:0]           res_rdata;
    logic                  res_err;

    assign size       = mem_size_e'(xif.x_mem_req_size_i);
    assign misaligned = is_misaligned(xif.x_mem_req_addr_i[1:0], size);

    assign obi.obi_req_o   = ~rst_i & xif.x_mem_valid_i & ~misaligned & ~full;
    assign xif.x_mem_ready_o = ~rst_i & ~full & (misaligned | obi.obi_gnt_i);
    assign obi.obi_addr_o  = {xif.x_mem_req_addr_i[31:2], 2'b00};
    assign obi.obi_we_o    = xif.x_mem_req_we_i;

    always_comb begin
        obi.obi_be_o    = 4'b0000;
        obi.obi_wdata_o = xif.x_mem_req_wdata_i;
        case (size)
            MEM_SIZE_BYTE: begin
                obi.obi_be_o    = 4'b0001 << xif.x_mem_req_addr_i[1:0];
                obi.obi_wdata_o = {4{xif.x_mem_req_wdata_i[7:0]}};
            end
            MEM_SIZE_HALF: begin
                obi.obi_be_o    = 4'b0011 << xif.x_mem_req_addr_i[1:0];
                obi.obi_wdata_o = {2{xif.x_mem_req_wdata_i[15:0]}};
            end
            MEM_SIZE_WORD: obi.obi_be_o = 4'b1111;
            default:       obi.obi_be_o = 4'b0000;
        endcase
    end

    assign push                = xif.x_mem_valid_i & xif.x_mem_ready_o;
    assign push_meta.id        = xif.x_mem_req_id_i;
    assign push_meta.local_err = misaligned;

    xif_mem_meta_fifo #(.DEPTH(MAX_OUTSTANDING)) u_meta_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (push),
        .push_data_i (push_meta),
        .pop_i       (pop),
        .full_o      (full),
        .empty_o     (empty),
        .head_o      (head),
        .count_o     (count)
    );

    // A bus response that lands while a local-error head is retiring (or while
    // an earlier parked response is being consumed) belongs to a younger entry;
    // park it for one cycle instead of dropping it.
    assign resp_valid = skid_valid | obi.obi_rvalid_i;
    assign resp_rdata = skid_valid ? skid_rdata : obi.obi_rdata_i;
    assign resp_err   = skid_valid ? skid_err   : obi.obi_err_i;
    assign pop        = ~empty & (head.local_err | resp_valid);
    assign skid_load  = pop & obi.obi_rvalid_i & (count > CNT_W'(1))
                      & (head.local_err | skid_valid);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            skid_valid <= 1'b0;
            skid_rdata <= '0;
            skid_err   <= 1'b0;
        end else if (skid_load) begin
            skid_valid <= 1'b1;
            skid_rdata <= obi.obi_rdata_i;
            skid_err   <= obi.obi_err_i;
        end else if (pop & ~head.local_err) begin
            skid_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            res_valid <= 1'b0;
            res_id    <= '0;
            res_rdata <= '0;
            res_err   <= 1'b0;
        end else begin
            res_valid <= pop;
            if (pop) begin
                res_id    <= head.id;
                res_rdata <= head.local_err ? '0 : resp_rdata;
                res_err   <= head.local_err | resp_err;
            end
        end
    end

    assign xif.x_mem_result_valid_o = res_valid;
    assign xif.x_mem_result_id_o    = res_id;
    assign xif.x_mem_result_rdata_o = res_rdata;
    assign xif.x_mem_result_err_o   = res_err;

    stray_rvalid_a: assert property (@(posedge clk_i) disable iff (rst_i)
        obi.obi_rvalid_i |-> !empty)
        else $warning("xif_mem_responder: obi response with nothing outstanding ignored");

    skid_overflow_a: assert property (@(posedge clk_i) disable iff (rst_i)
        !(skid_valid && head.local_err && skid_load))
        else $error("xif_mem_responder: parked response overwritten");

endmodule

// File: tb/tb_xif_mem_responder.sv
// Directed bench for xif_mem_responder: address-phase vector table plus
// hand-written multi-cycle sequences for ordering, stalls, errors and reset.
module tb_xif_mem_responder;
    import fpu_ss_pkg::*;

    logic clk;
    logic rst;
    int   checks = 0;
    int   passes = 0;
    int   pulses = 0;

    xif_mem_if xif ();
    obi_if     obi ();

    xif_mem_responder #(.MAX_OUTSTANDING(2)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .xif   (xif.slave),
        .obi   (obi.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (xif.x_mem_result_valid_o === 1'b1) pulses++;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $display("%0d/%0d checks passed", passes, checks + 1);
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
        logic [1:0]  size;
        logic        gnt;
        logic        exp_req;
        logic        exp_ready;
        logic        chk_bus;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h required %h", name, act, exp);
    endtask

    task automatic issue(input logic [X_ID_WIDTH-1:0] id, input logic [31:0] addr,
                         input logic [1:0] size, input logic exp_req, input string name);
        int w;
        @(negedge clk);
        xif.x_mem_valid_i     = 1'b1;
        xif.x_mem_req_id_i    = id;
        xif.x_mem_req_addr_i  = addr;
        xif.x_mem_req_size_i  = size;
        xif.x_mem_req_we_i    = 1'b0;
        xif.x_mem_req_wdata_i = '0;
        #1;
        w = 0;
        while (xif.x_mem_ready_o !== 1'b1 && w < 20) begin
            @(negedge clk); #1; w++;
        end
        chk({name, "_ready"}, {31'b0, xif.x_mem_ready_o}, 32'd1);
        chk({name, "_req"}, {31'b0, obi.obi_req_o}, {31'b0, exp_req});
        @(posedge clk); #1;
        xif.x_mem_valid_i = 1'b0;
    endtask

    task automatic drive_rvalid(input logic [31:0] rdata, input logic err);
        @(posedge clk); #1;
        obi.obi_rvalid_i = 1'b1;
        obi.obi_rdata_i  = rdata;
        obi.obi_err_i    = err;
        @(posedge clk); #1;
        obi.obi_rvalid_i = 1'b0;
        obi.obi_rdata_i  = '0;
        obi.obi_err_i    = 1'b0;
    endtask

    task automatic expect_result(input logic [X_ID_WIDTH-1:0] id, input logic [31:0] rdata,
                                 input logic err, input string name);
        @(negedge clk);
        chk({name, "_valid"}, {31'b0, xif.x_mem_result_valid_o}, 32'd1);
        chk({name, "_id"}, 32'(xif.x_mem_result_id_o), 32'(id));
        chk({name, "_rdata"}, xif.x_mem_result_rdata_o, rdata);
        chk({name, "_err"}, {31'b0, xif.x_mem_result_err_o}, {31'b0, err});
    endtask

    task automatic expect_idle(input string name);
        @(negedge clk);
        chk({name, "_valid"}, {31'b0, xif.x_mem_result_valid_o}, 32'd0);
    endtask

    initial begin
        int base;
        vecs[0] = '{32'h0000_0100, 32'h1234_5678, 1'b0, 2'd2, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0100, 4'b1111, 32'h1234_5678};
        vecs[1] = '{32'h0000_0203, 32'h0000_00A5, 1'b1, 2'd0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0200, 4'b1000, 32'hA5A5_A5A5};
        vecs[2] = '{32'h0000_0102, 32'h1234_BEEF, 1'b1, 2'd1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0100, 4'b1100, 32'hBEEF_BEEF};
        vecs[3] = '{32'h0000_0001, 32'h0000_003C, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0000, 4'b0010, 32'h3C3C_3C3C};
        vecs[4] = '{32'h0000_0F00, 32'hCAFE_5A5A, 1'b1, 2'd1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0F00, 4'b0011, 32'h5A5A_5A5A};
        vecs[5] = '{32'h0000_0101, 32'h0000_0000, 1'b0, 2'd1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 4'b0, 32'h0};
        vecs[6] = '{32'h0000_0102, 32'h0000_0000, 1'b0, 2'd2, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 4'b0, 32'h0};
        vecs[7] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 2'd3, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 4'b0, 32'h0};
        vecs[8] = '{32'hFFFF_FFFF, 32'h0000_0077, 1'b1, 2'd0, 1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC, 4'b1000, 32'h7777_7777};

        rst = 1'b1;
        xif.x_mem_valid_i     = 1'b1;
        xif.x_mem_req_id_i    = '0;
        xif.x_mem_req_addr_i  = 32'h0000_0100;
        xif.x_mem_req_wdata_i = '0;
        xif.x_mem_req_we_i    = 1'b0;
        xif.x_mem_req_size_i  = 2'd2;
        obi.obi_gnt_i    = 1'b1;
        obi.obi_rvalid_i = 1'b0;
        obi.obi_rdata_i  = '0;
        obi.obi_err_i    = 1'b0;

        repeat (2) @(negedge clk);
        #1;
        chk("rst_ready", {31'b0, xif.x_mem_ready_o}, 32'd0);
        chk("rst_req", {31'b0, obi.obi_req_o}, 32'd0);
        chk("rst_res_valid", {31'b0, xif.x_mem_result_valid_o}, 32'd0);
        chk("rst_res_id", 32'(xif.x_mem_result_id_o), 32'd0);
        chk("rst_res_rdata", xif.x_mem_result_rdata_o, 32'd0);
        chk("rst_res_err", {31'b0, xif.x_mem_result_err_o}, 32'd0);
        xif.x_mem_valid_i = 1'b0;
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            xif.x_mem_valid_i     = 1'b1;
            xif.x_mem_req_addr_i  = vecs[i].addr;
            xif.x_mem_req_wdata_i = vecs[i].wdata;
            xif.x_mem_req_we_i    = vecs[i].we;
            xif.x_mem_req_size_i  = vecs[i].size;
            obi.obi_gnt_i         = vecs[i].gnt;
            #1;
            chk($sformatf("v%0d_req", i), {31'b0, obi.obi_req_o}, {31'b0, vecs[i].exp_req});
            chk($sformatf("v%0d_ready", i), {31'b0, xif.x_mem_ready_o}, {31'b0, vecs[i].exp_ready});
            if (vecs[i].chk_bus) begin
                chk($sformatf("v%0d_addr", i), obi.obi_addr_o, vecs[i].exp_addr);
                chk($sformatf("v%0d_be", i), {28'b0, obi.obi_be_o}, {28'b0, vecs[i].exp_be});
                chk($sformatf("v%0d_wdata", i), obi.obi_wdata_o, vecs[i].exp_wdata);
                chk($sformatf("v%0d_we", i), {31'b0, obi.obi_we_o}, {31'b0, vecs[i].we});
            end
            #1;
            xif.x_mem_valid_i = 1'b0;
            obi.obi_gnt_i     = 1'b0;
        end
        chk("vec_no_result", 32'(pulses), 32'd0);

        obi.obi_gnt_i = 1'b1;

        // Single word load, response two cycles after acceptance.
        issue(4'd3, 32'h0000_0100, 2'd2, 1'b1, "ld3");
        drive_rvalid(32'hDEAD_BEEF, 1'b0);
        expect_result(4'd3, 32'hDEAD_BEEF, 1'b0, "res3");
        expect_idle("res3_once");

        // Lone misaligned request completes locally one cycle after acceptance.
        issue(4'd10, 32'h0000_0003, 2'd2, 1'b0, "mis10");
        expect_idle("mis10_wait");
        expect_result(4'd10, 32'h0, 1'b1, "res10");
        expect_idle("res10_once");

        // Local error queued behind a pending bus load must not overtake it.
        issue(4'd1, 32'h0000_0040, 2'd2, 1'b1, "ld1");
        issue(4'd2, 32'h0000_0101, 2'd1, 1'b0, "mis2");
        drive_rvalid(32'h1111_1111, 1'b0);
        expect_result(4'd1, 32'h1111_1111, 1'b0, "ord1");
        expect_result(4'd2, 32'h0, 1'b1, "ord2");
        expect_idle("ord_done");

        // Third load stalls while two are outstanding.
        issue(4'd4, 32'h0000_0010, 2'd2, 1'b1, "ld4");
        issue(4'd6, 32'h0000_0014, 2'd2, 1'b1, "ld6");
        @(negedge clk);
        xif.x_mem_valid_i    = 1'b1;
        xif.x_mem_req_id_i   = 4'd7;
        xif.x_mem_req_addr_i = 32'h0000_0018;
        xif.x_mem_req_size_i = 2'd2;
        #1;
        chk("stall_ready_a", {31'b0, xif.x_mem_ready_o}, 32'd0);
        chk("stall_req_a", {31'b0, obi.obi_req_o}, 32'd0);
        @(negedge clk); #1;
        chk("stall_ready_b", {31'b0, xif.x_mem_ready_o}, 32'd0);
        obi.obi_rvalid_i = 1'b1;
        obi.obi_rdata_i  = 32'h4444_4444;
        @(posedge clk); #1;
        obi.obi_rvalid_i = 1'b0;
        obi.obi_rdata_i  = '0;
        chk("unstall_ready", {31'b0, xif.x_mem_ready_o}, 32'd1);
        chk("unstall_req", {31'b0, obi.obi_req_o}, 32'd1);
        expect_result(4'd4, 32'h4444_4444, 1'b0, "res4");
        @(posedge clk); #1;
        xif.x_mem_valid_i = 1'b0;
        drive_rvalid(32'h6666_6666, 1'b0);
        expect_result(4'd6, 32'h6666_6666, 1'b0, "res6");
        drive_rvalid(32'h7777_7777, 1'b0);
        expect_result(4'd7, 32'h7777_7777, 1'b0, "res7");
        expect_idle("res7_once");

        // Bus error propagates to the result.
        issue(4'd5, 32'h0000_0020, 2'd2, 1'b1, "ld5");
        drive_rvalid(32'hCAFE_F00D, 1'b1);
        expect_result(4'd5, 32'hCAFE_F00D, 1'b1, "res5");
        expect_idle("res5_once");

        // Reset with two loads in flight drops them; late responses are ignored.
        issue(4'd8, 32'h0000_0030, 2'd2, 1'b1, "ld8");
        issue(4'd9, 32'h0000_0034, 2'd2, 1'b1, "ld9");
        base = pulses;
        @(negedge clk);
        rst = 1'b1;
        xif.x_mem_valid_i    = 1'b1;
        xif.x_mem_req_addr_i = 32'h0000_0040;
        xif.x_mem_req_size_i = 2'd2;
        #1;
        chk("mid_rst_ready", {31'b0, xif.x_mem_ready_o}, 32'd0);
        chk("mid_rst_req", {31'b0, obi.obi_req_o}, 32'd0);
        chk("mid_rst_id", 32'(xif.x_mem_result_id_o), 32'd0);
        chk("mid_rst_rdata", xif.x_mem_result_rdata_o, 32'd0);
        chk("mid_rst_err", {31'b0, xif.x_mem_result_err_o}, 32'd0);
        xif.x_mem_valid_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", {31'b0, xif.x_mem_ready_o}, 32'd1);
        drive_rvalid(32'h8888_8888, 1'b0);
        drive_rvalid(32'h9999_9999, 1'b0);
        repeat (3) @(negedge clk);
        chk("post_rst_no_result", 32'(pulses - base), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/xif_mem_responder.md
XIF_MEM_RESPONDER -- requirements
Module: xif_mem_responder

Interface
REQ-001 SHALL have parameter MAX_OUTSTANDING, default 2, max in-flight requests (1..4).
REQ-002 SHALL use X_ID_WIDTH from fpu_ss_pkg as the instruction id width.
REQ-003 clk_i  input  1  the only clock; all state updates on its rising edge.
REQ-004 rst_i  input  1  reset, asynchronous and active-high.
REQ-005 x_mem_valid_i / x_mem_ready_o  in/out  1/1  coprocessor memory request handshake.
REQ-006 x_mem_req_id_i  input  X_ID_WIDTH  instruction id.
REQ-007 x_mem_req_addr_i / x_mem_req_wdata_i  input  32/32  byte address, store data (LSB-aligned).
REQ-008 x_mem_req_we_i / x_mem_req_size_i  input  1/2  store flag, size (0 byte, 1 half, 2 word; 3 illegal).
REQ-009 x_mem_result_valid_o  output  1  one-cycle result pulse; no ready.
REQ-010 x_mem_result_id_o / x_mem_result_rdata_o / x_mem_result_err_o  output  X_ID_WIDTH/32/1  result id, raw load word, error.
REQ-011 obi_req_o / obi_gnt_i  out/in  1/1  data-bus address-phase handshake.
REQ-012 obi_addr_o / obi_we_o / obi_be_o / obi_wdata_o  output  32/1/4/32  word address, write flag, byte enables, lane-replicated data.
REQ-013 obi_rvalid_i / obi_rdata_i / obi_err_i  input  1/32/1  response phase, one per granted request, in order.

Function
REQ-014 Request SHALL be misaligned when size=3, size=1 with addr[0]=1, or size=2 with addr[1:0]!=0.
REQ-015 Aligned request: obi_req_o = x_mem_valid_i & ~full; x_mem_ready_o = obi_gnt_i & ~full; accepted on obi_req_o & obi_gnt_i.
REQ-016 Misaligned request: obi_req_o=0; x_mem_ready_o = ~full; accepted without bus transaction, marked local error.
REQ-017 obi_addr_o SHALL be {addr[31:2],2'b00}; obi_be_o 0001<<addr[1:0] (byte), 0011<<addr[1:0] (half), 1111 (word).
REQ-018 obi_wdata_o SHALL replicate byte 4x for size 0, half 2x for size 1, word unchanged.
REQ-019 Each accept SHALL push {id, local_err} into an in-order metadata FIFO; full when count==MAX_OUTSTANDING.
REQ-020 Head normal: pop on obi_rvalid_i; head local_err: pop in the first cycle it is head.
REQ-021 Result outputs SHALL be registered: x_mem_result_valid_o asserts exactly 1 cycle after the pop, with head id, rdata=obi_rdata_i (0 on local error), err=obi_err_i | local_err.
REQ-022 Results SHALL leave in acceptance order; a local error SHALL NOT overtake older bus responses.
REQ-023 Simultaneous push and pop SHALL keep count unchanged and be legal when full (pop frees space only next cycle: ready uses registered full).
REQ-024 obi_rvalid_i with empty FIFO SHALL be ignored (no result); flagged by assertion.
REQ-025 Address-phase outputs SHALL be held stable while obi_req_o=1 and obi_gnt_i=0 (driven from inputs; requester holds them per protocol).
REQ-026 Count SHALL use $clog2(MAX_OUTSTANDING+1) bits; FIFO pointers wrap modulo MAX_OUTSTANDING.

Reset
REQ-027 On rst_i assertion, asynchronously: FIFO empty, count 0, x_mem_result_valid_o=0, id/rdata/err=0.
REQ-028 Reset mid-transaction SHALL drop in-flight entries; later stray obi_rvalid_i SHALL be ignored per REQ-024.
REQ-029 While rst_i=1, x_mem_ready_o=0 and obi_req_o=0.

Structure
REQ-030 fpu_ss_pkg SHALL hold X_ID_WIDTH, a mem_size_e enum and a mem_resp_meta_t struct {id, local_err}.
REQ-031 The metadata FIFO SHALL be one sub-module, xif_mem_meta_fifo (depth MAX_OUTSTANDING, push/pop/full/empty/head).
REQ-032 Byte-enable and wdata replication SHALL be combinational in the top level.

Verification
REQ-033 Word load id=3 addr=0x100, gnt same cycle, rvalid 2 cycles later rdata=0xDEADBEEF -> one result pulse id=3, rdata=0xDEADBEEF, err=0, 1 cycle after rvalid.
REQ-034 Byte store addr=0x203 wdata=0xA5 -> obi_addr=0x200, be=1000, wdata=0xA5A5A5A5, we=1.
REQ-035 Word load id=1 pending, then half load id=2 addr=0x101 -> no bus request for id=2; results id=1 then id=2 (err=1) in order.
REQ-036 Three word loads, MAX_OUTSTANDING=2, gnt held 1, rvalid delayed -> third stalled (x_mem_ready_o=0) until first rvalid pops.
REQ-037 obi_err_i=1 on response id=5 -> result id=5 err=1; rst_i pulse with 2 in flight -> no results, later rvalids produce nothing.
